// File: rtl/non_max_suppression_pkg.sv
// Shared types for the Canny non-maximum suppression stage: default image
// geometry, quantised gradient direction and the packed gradient word.
package non_max_suppression_pkg;

  localparam int WIDTH  = 720;
  localparam int HEIGHT = 540;

  typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;

  typedef struct packed {
    dir_t       dir;
    logic [7:0] mag;
  } grad_t;

endpackage

// File: rtl/nms_compare.sv
// Keeps the centre magnitude only if it is a local maximum along its
// gradient direction; ties with a neighbour are kept.
module nms_compare
  import non_max_suppression_pkg::*;
(
  input  logic [9:0] center_i,
  input  logic [7:0] tl_i,
  input  logic [7:0] t_i,
  input  logic [7:0] tr_i,
  input  logic [7:0] l_i,
  input  logic [7:0] r_i,
  input  logic [7:0] bl_i,
  input  logic [7:0] b_i,
  input  logic [7:0] br_i,
  output logic [7:0] result_o
);

  grad_t      c;
  logic [7:0] na;
  logic [7:0] nb;

  assign c = grad_t'(center_i);

  always_comb begin
    na = '0;
    nb = '0;
    case (c.dir)
      DIR_0:   begin na = l_i;  nb = r_i;  end
      DIR_45:  begin na = tr_i; nb = bl_i; end
      DIR_90:  begin na = t_i;  nb = b_i;  end
      DIR_135: begin na = tl_i; nb = br_i; end
    endcase
    result_o = (c.mag >= na && c.mag >= nb) ? c.mag : 8'd0;
  end

endmodule

// File: rtl/non_max_suppression.sv
// Streams gradient words through a two-line window and emits one suppressed
// magnitude per pixel in raster order, alternating COMPUTE and OUTPUT.
module non_max_suppression #(
  parameter int WIDTH  = non_max_suppression_pkg::WIDTH,
  parameter int HEIGHT = non_max_suppression_pkg::HEIGHT
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [9:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din,
  output logic       frame_done
);
  import non_max_suppression_pkg::*;

  localparam int SHIFT_REG_LEN = 2*WIDTH + 3;
  localparam int COL_W         = $clog2(WIDTH);
  localparam int ROW_W         = $clog2(HEIGHT);
  localparam int CNT_W         = $clog2(WIDTH + 3);
  localparam int NPIX          = WIDTH * HEIGHT;

  typedef enum logic [1:0] {PROLOGUE, COMPUTE, OUTPUT} state_t;

  state_t           state_q, state_d;
  grad_t            sr_q [SHIFT_REG_LEN];
  grad_t            sr_d [SHIFT_REG_LEN];
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [7:0]       result_q, result_d;

  logic       shift_en;
  grad_t      shift_word;
  logic       rd_en, wr_en, done;
  logic       tail, border, last_pix;
  logic [7:0] cmp_result;
  logic [31:0] pix;

  assign pix      = 32'(row_q) * 32'(WIDTH) + 32'(col_q);
  // The word that would enter now is pixel pix+WIDTH+2; beyond the frame end
  // it belongs to the next frame, so zero is shifted in instead.
  assign tail     = (pix + 32'(WIDTH + 2)) >= 32'(NPIX);
  assign border   = (row_q == '0) || (row_q == ROW_W'(HEIGHT - 1)) ||
                    (col_q == '0) || (col_q == COL_W'(WIDTH - 1));
  assign last_pix = (row_q == ROW_W'(HEIGHT - 1)) && (col_q == COL_W'(WIDTH - 1));

  nms_compare u_compare (
    .center_i (sr_q[WIDTH+1]),
    .tl_i     (sr_q[0].mag),
    .t_i      (sr_q[1].mag),
    .tr_i     (sr_q[2].mag),
    .l_i      (sr_q[WIDTH].mag),
    .r_i      (sr_q[WIDTH+2].mag),
    .bl_i     (sr_q[2*WIDTH].mag),
    .b_i      (sr_q[2*WIDTH+1].mag),
    .br_i     (sr_q[2*WIDTH+2].mag),
    .result_o (cmp_result)
  );

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    counter_d  = counter_q;
    result_d   = result_q;
    shift_en   = 1'b0;
    shift_word = '0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;
    case (state_q)
      PROLOGUE: begin
        if (!in_empty) begin
          rd_en      = 1'b1;
          shift_en   = 1'b1;
          shift_word = grad_t'(in_dout);
          counter_d  = counter_q + CNT_W'(1);
          if (counter_q == CNT_W'(WIDTH + 1)) state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        if (tail || !in_empty) begin
          shift_en = 1'b1;
          if (!tail) begin
            rd_en      = 1'b1;
            shift_word = grad_t'(in_dout);
          end
          result_d = border ? 8'd0 : cmp_result;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        if (!out_full) begin
          wr_en = 1'b1;
          if (last_pix) begin
            done      = 1'b1;
            row_d     = '0;
            col_d     = '0;
            counter_d = '0;
            result_d  = '0;
            state_d   = PROLOGUE;
          end else begin
            if (col_q == COL_W'(WIDTH - 1)) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            state_d = COMPUTE;
          end
        end
      end
      default: state_d = PROLOGUE;
    endcase
  end

  always_comb begin
    sr_d = sr_q;
    if (shift_en) begin
      for (int i = 0; i < SHIFT_REG_LEN - 1; i++) sr_d[i] = sr_q[i+1];
      sr_d[SHIFT_REG_LEN-1] = shift_word;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= PROLOGUE;
      col_q     <= '0;
      row_q     <= '0;
      counter_q <= '0;
      result_q  <= '0;
      for (int i = 0; i < SHIFT_REG_LEN; i++) sr_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      counter_q <= counter_d;
      result_q  <= result_d;
      sr_q      <= sr_d;
    end
  end

  // Outputs are forced low while reset is held so FIFOs see no strobes.
  assign in_rd_en   = rd_en & ~reset;
  assign out_wr_en  = wr_en & ~reset;
  assign frame_done = done & ~reset;
  assign out_din    = reset ? 8'd0 : result_q;

endmodule

// File: tb/tb_non_max_suppression.sv
// Directed bench for non_max_suppression on an 8x6 image, with a FWFT input
// FIFO model, an output capture monitor and a 2D golden model.
module tb_non_max_suppression;
  import non_max_suppression_pkg::*;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NPIX = W * H;

  typedef logic [9:0] frame_t [NPIX];

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_rd_en;
  logic       in_empty = 1'b1;
  logic [9:0] in_dout = '0;
  logic       out_wr_en;
  logic       out_full = 1'b0;
  logic [7:0] out_din;
  logic       frame_done;

  non_max_suppression #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_rd_en   (in_rd_en),
    .in_empty   (in_empty),
    .in_dout    (in_dout),
    .out_wr_en  (out_wr_en),
    .out_full   (out_full),
    .out_din    (out_din),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int testCount = 0;
  int failCount = 0;

  logic [9:0] inQ[$];
  int popCount = 0;
  bit bubbleEn = 1'b0;

  int gotData[$];
  int doneAt[$];
  int popsAtDone[$];
  int writeCount = 0;
  int strayDone  = 0;

  task automatic checkOutput(input string tag, input int got, input int exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] mkWord(input int dir, input int mag);
    grad_t g;
    g.dir = dir_t'(dir[1:0]);
    g.mag = mag[7:0];
    return g;
  endfunction

  function automatic frame_t fillFrame(input int dir, input int mag);
    frame_t f;
    for (int p = 0; p < NPIX; p++) f[p] = mkWord(dir, mag);
    return f;
  endfunction

  // Golden model indexed directly in 2D image coordinates.
  function automatic int modelPix(input frame_t f, input int p);
    int r, c, m, a, b;
    grad_t g;
    r = p / W;
    c = p % W;
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
    g = grad_t'(f[p]);
    m = int'(g.mag);
    case (g.dir)
      DIR_0:   begin a = int'(f[p-1][7:0]);   b = int'(f[p+1][7:0]);   end
      DIR_45:  begin a = int'(f[p-W+1][7:0]); b = int'(f[p+W-1][7:0]); end
      DIR_90:  begin a = int'(f[p-W][7:0]);   b = int'(f[p+W][7:0]);   end
      default: begin a = int'(f[p-W-1][7:0]); b = int'(f[p+W+1][7:0]); end
    endcase
    return (m >= a && m >= b) ? m : 0;
  endfunction

  // Input FIFO model: pops on the edge, refreshes FWFT data 2 ns later.
  initial begin
    bit rd;
    bit bubble;
    forever begin
      @(negedge clock);
      rd = in_rd_en;
      @(posedge clock);
      if (rd && inQ.size() > 0) begin
        void'(inQ.pop_front());
        popCount++;
      end
      #2;
      bubble   = bubbleEn && ($urandom_range(0, 3) == 0);
      in_empty = (inQ.size() == 0) || bubble;
      in_dout  = (inQ.size() > 0) ? inQ[0] : 10'h000;
    end
  end

  // Output monitor: a write sampled mid-cycle commits on the next edge.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (out_wr_en && !out_full) begin
          gotData.push_back(int'(out_din));
          writeCount++;
          if (frame_done) begin
            doneAt.push_back(writeCount);
            popsAtDone.push_back(popCount);
          end
        end else if (frame_done) begin
          strayDone++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input frame_t f);
    for (int p = 0; p < NPIX; p++) inQ.push_back(f[p]);
  endtask

  task automatic clearCapture();
    gotData.delete();
    doneAt.delete();
    popsAtDone.delete();
    writeCount = 0;
    popCount   = 0;
  endtask

  task automatic waitWrites(input int n);
    int c = 0;
    while (writeCount < n && c < 3000) begin
      @(posedge clock); #1;
      c++;
    end
    if (writeCount < n) checkOutput("timeout_writes", writeCount, n);
  endtask

  task automatic checkFrame(input string tag, input frame_t f, input int base);
    int got;
    for (int p = 0; p < NPIX; p++) begin
      got = (base + p < gotData.size()) ? gotData[base+p] : -1;
      checkOutput($sformatf("%s_px%0d", tag, p), got, modelPix(f, p));
    end
  endtask

  task automatic runFrame(input string tag, input frame_t f);
    clearCapture();
    applyStimulus(f);
    waitWrites(NPIX);
    repeat (6) begin @(posedge clock); #1; end
    checkOutput({tag, "_writes"}, writeCount, NPIX);
    checkOutput({tag, "_doneCount"}, doneAt.size(), 1);
    checkFrame(tag, f, 0);
  endtask

  initial begin
    frame_t fA, fB, fC, fD1, fD3, fS, fE1, fE2, fF1, fF2;
    int wcHold;
    int held;

    fA = fillFrame(0, 10);
    fB = fillFrame(0, 50);
    fB[19] = mkWord(0, 100);
    fC = fB;  fC[19]  = mkWord(2, 100); fC[11]  = mkWord(0, 120);
    fD1 = fB; fD1[19] = mkWord(1, 100); fD1[12] = mkWord(0, 120);
    fD3 = fB; fD3[19] = mkWord(3, 100); fD3[10] = mkWord(0, 120);
    for (int p = 0; p < NPIX; p++) begin
      fS[p]  = mkWord(p % 4, (p * 37) % 256);
      fE1[p] = mkWord(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      fE2[p] = mkWord(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      fF1[p] = mkWord(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      fF2[p] = mkWord(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end

    // Reset values, during and right after reset.
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_rd_en", in_rd_en, 0);
    checkOutput("rst_wr_en", out_wr_en, 0);
    checkOutput("rst_din", out_din, 0);
    checkOutput("rst_done", frame_done, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_rst_wr_en", out_wr_en, 0);
    checkOutput("post_rst_din", out_din, 0);
    @(posedge clock); #1;

    // Flat frame: interior ties kept, borders zero, frame_done on write 48.
    runFrame("A", fA);
    checkOutput("A_doneAt", (doneAt.size() > 0) ? doneAt[0] : -1, NPIX);
    checkOutput("A_interior", gotData[9], 10);
    checkOutput("A_border", gotData[0], 0);

    // Single horizontal peak and its suppressed neighbours.
    runFrame("B", fB);
    checkOutput("B_peak", gotData[19], 100);
    checkOutput("B_left", gotData[18], 0);
    checkOutput("B_right", gotData[20], 0);

    runFrame("C90", fC);
    checkOutput("C90_peak", gotData[19], 0);
    runFrame("C45", fD1);
    checkOutput("C45_peak", gotData[19], 0);
    runFrame("C135", fD3);
    checkOutput("C135_peak", gotData[19], 0);

    // Output back-pressure mid-frame.
    clearCapture();
    applyStimulus(fS);
    waitWrites(20);
    out_full = 1'b1;
    wcHold   = writeCount;
    held     = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clock);
      checkOutput("D_stall_wren", out_wr_en, 0);
      if (i == 2) held = int'(out_din);
      else if (i > 2) checkOutput("D_hold_din", out_din, held);
    end
    @(posedge clock); #1;
    checkOutput("D_no_write", writeCount, wcHold);
    out_full = 1'b0;
    waitWrites(NPIX);
    repeat (6) begin @(posedge clock); #1; end
    checkOutput("D_writes", writeCount, NPIX);
    checkFrame("D", fS, 0);

    // Back-to-back frames with input bubbles.
    clearCapture();
    bubbleEn = 1'b1;
    applyStimulus(fE1);
    applyStimulus(fE2);
    waitWrites(2 * NPIX);
    repeat (6) begin @(posedge clock); #1; end
    bubbleEn = 1'b0;
    checkOutput("E_writes", writeCount, 2 * NPIX);
    checkOutput("E_doneCount", doneAt.size(), 2);
    checkOutput("E_done0", (doneAt.size() > 0) ? doneAt[0] : -1, NPIX);
    checkOutput("E_done1", (doneAt.size() > 1) ? doneAt[1] : -1, 2 * NPIX);
    checkOutput("E_pops0", (popsAtDone.size() > 0) ? popsAtDone[0] : -1, NPIX);
    checkOutput("E_pops1", (popsAtDone.size() > 1) ? popsAtDone[1] : -1, 2 * NPIX);
    checkFrame("E1", fE1, 0);
    checkFrame("E2", fE2, NPIX);

    // Reset mid-frame, system flushes the input FIFO, then a fresh frame.
    clearCapture();
    applyStimulus(fF1);
    waitWrites(10);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("F_rst_rd_en", in_rd_en, 0);
    checkOutput("F_rst_wr_en", out_wr_en, 0);
    checkOutput("F_rst_din", out_din, 0);
    checkOutput("F_rst_done", frame_done, 0);
    inQ.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    runFrame("F", fF2);

    checkOutput("stray_done", strayDone, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
